// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit pipeline and instruction-memory bundle
interface fetch_unit_if #(
  parameter int WORD_SIZE = 32
);
  logic                 stall;
  logic                 redirect;
  logic [WORD_SIZE-1:0] redirect_pc;
  logic                 imem_req;
  logic [WORD_SIZE-1:0] imem_addr;
  logic                 imem_gnt;
  logic                 imem_rvalid;
  logic [WORD_SIZE-1:0] imem_rdata;
  logic [WORD_SIZE-1:0] instruction_out;
  logic [WORD_SIZE-1:0] pc_out;
  logic                 valid_out;

  // fetch unit side
  modport master (
    input  stall, redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, instruction_out, pc_out, valid_out
  );

  // memory / pipeline side
  modport slave (
    output stall, redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, instruction_out, pc_out, valid_out
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch with skid slot and redirect flush
module fetch_unit #(
  parameter int                   WORD_SIZE = 32,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  fetch_if
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_e;

  localparam logic [WORD_SIZE-1:0] PC_STEP    = WORD_SIZE'(4);
  localparam logic [WORD_SIZE-1:0] ALIGN_MASK = ~WORD_SIZE'(3);

  state_e               state_q, state_d;
  logic [WORD_SIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_SIZE-1:0] req_pc_q, req_pc_d;
  logic [WORD_SIZE-1:0] skid_instr_q, skid_instr_d;
  logic [WORD_SIZE-1:0] skid_pc_q, skid_pc_d;
  logic [WORD_SIZE-1:0] instr_q, instr_d;
  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic                 valid_q, valid_d;
  logic                 req_c;
  logic                 granted_c;
  logic                 slot_free_c;

  // state register plus output slot and skid entry; reset abandons any outstanding request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_REQ;
      fetch_pc_q   <= RESET_PC;
      req_pc_q     <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      instr_q      <= '0;
      pc_q         <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_pc_q     <= req_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
    end
  end

  // next-state, slot/skid movement and request generation; redirect overrides everything
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_pc_d     = req_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    // a live slot survives only while the consumer stalls
    valid_d      = valid_q & fetch_if.stall;
    req_c        = 1'b0;
    granted_c    = 1'b0;
    slot_free_c  = !valid_q || !fetch_if.stall;

    case (state_q)
      S_REQ: begin
        req_c     = !(valid_q && fetch_if.stall);
        granted_c = req_c && fetch_if.imem_gnt;
        if (granted_c) begin
          req_pc_d = fetch_pc_q;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (fetch_if.imem_rvalid) begin
          fetch_pc_d = req_pc_q + PC_STEP;
          if (slot_free_c) begin
            instr_d = fetch_if.imem_rdata;
            pc_d    = req_pc_q;
            valid_d = 1'b1;
            state_d = S_REQ;
          end else begin
            skid_instr_d = fetch_if.imem_rdata;
            skid_pc_d    = req_pc_q;
            state_d      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!fetch_if.stall) begin
          instr_d = skid_instr_q;
          pc_d    = skid_pc_q;
          valid_d = 1'b1;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (fetch_if.imem_rvalid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (fetch_if.redirect) begin
      fetch_pc_d   = fetch_if.redirect_pc & ALIGN_MASK;
      valid_d      = 1'b0;
      instr_d      = instr_q;
      pc_d         = pc_q;
      skid_instr_d = '0;
      skid_pc_d    = '0;
      case (state_q)
        // a response still owed by memory must be swallowed in DROP
        S_REQ:   state_d = granted_c ? S_DROP : S_REQ;
        S_WAIT:  state_d = fetch_if.imem_rvalid ? S_REQ : S_DROP;
        S_HOLD:  state_d = S_REQ;
        S_DROP:  state_d = S_DROP;
        default: state_d = S_REQ;
      endcase
    end
  end

  assign fetch_if.imem_req        = req_c & ~rst;
  assign fetch_if.imem_addr       = fetch_pc_q;
  assign fetch_if.instruction_out = instr_q;
  assign fetch_if.pc_out          = pc_q;
  assign fetch_if.valid_out       = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector bench for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  typedef struct {
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic rst1;

  int n_cmp  = 0;
  int n_fail = 0;

  int          rv_delay;
  int          pend0;
  int          pend1;
  logic [31:0] paddr0;
  logic [31:0] paddr1;

  vec_t vecs[11];

  always #5 clk = ~clk;

  fetch_unit_if #(.WORD_SIZE(32)) bus0 ();
  fetch_unit_if #(.WORD_SIZE(32)) bus1 ();

  fetch_unit #(.WORD_SIZE(32), .RESET_PC(32'h0000_0000)) dut0 (
    .clk      (clk),
    .rst      (rst),
    .fetch_if (bus0.master)
  );

  fetch_unit #(.WORD_SIZE(32), .RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk      (clk),
    .rst      (rst1),
    .fetch_if (bus1.master)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // one clock; the memory model answers each grant rv_delay cycles later
  task automatic step();
    logic        g0, g1;
    logic [31:0] a0, a1;
    #1;
    g0 = bus0.imem_req && bus0.imem_gnt;
    a0 = bus0.imem_addr;
    g1 = bus1.imem_req && bus1.imem_gnt;
    a1 = bus1.imem_addr;
    @(posedge clk);
    @(negedge clk);
    bus0.imem_rvalid = 1'b0;
    bus1.imem_rvalid = 1'b0;
    if (g0) begin
      pend0  = rv_delay;
      paddr0 = a0;
    end
    if (pend0 > 0) begin
      pend0--;
      if (pend0 == 0) begin
        bus0.imem_rvalid = 1'b1;
        bus0.imem_rdata  = paddr0 ^ KEY;
      end
    end
    if (g1) begin
      pend1  = 1;
      paddr1 = a1;
    end
    if (pend1 > 0) begin
      pend1--;
      if (pend1 == 0) begin
        bus1.imem_rvalid = 1'b1;
        bus1.imem_rdata  = paddr1 ^ KEY;
      end
    end
  endtask

  task automatic reset_all();
    rst              = 1'b1;
    pend0            = 0;
    rv_delay         = 1;
    bus0.stall       = 1'b0;
    bus0.redirect    = 1'b0;
    bus0.redirect_pc = '0;
    bus0.imem_gnt    = 1'b1;
    bus0.imem_rvalid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    rst1             = 1'b1;
    rv_delay         = 1;
    pend0            = 0;
    pend1            = 0;
    paddr0           = '0;
    paddr1           = '0;
    bus0.stall       = 1'b0;
    bus0.redirect    = 1'b0;
    bus0.redirect_pc = '0;
    bus0.imem_gnt    = 1'b1;
    bus0.imem_rvalid = 1'b0;
    bus0.imem_rdata  = '0;
    bus1.stall       = 1'b0;
    bus1.redirect    = 1'b0;
    bus1.redirect_pc = '0;
    bus1.imem_gnt    = 1'b1;
    bus1.imem_rvalid = 1'b0;
    bus1.imem_rdata  = '0;

    // stall, req, addr, valid, pc, instr
    vecs[0]  = '{1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'hA5A5_A5A5};
    vecs[2]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 32'hA5A5_A5A5};
    vecs[3]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 32'hA5A5_A5A5};
    vecs[4]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 32'hA5A5_A5A5};
    vecs[5]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 32'hA5A5_A5A5};
    vecs[6]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 32'hA5A5_A5A5};
    vecs[7]  = '{1'b0, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h4, 32'hA5A5_A5A1};
    vecs[9]  = '{1'b0, 1'b1, 32'h8, 1'b0, 32'h0, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 32'hA5A5_A5AD};

    @(negedge clk);
    #1;
    chk("rst_valid", 32'(bus0.valid_out), 32'd0);
    chk("rst_pc", bus0.pc_out, 32'h0);
    chk("rst_instr", bus0.instruction_out, 32'h0);
    chk("rst_req", 32'(bus0.imem_req), 32'd0);
    chk("rst1_req", 32'(bus1.imem_req), 32'd0);

    // sequential fetch with a five-cycle stall on the first instruction
    reset_all();
    for (int i = 0; i < 11; i++) begin
      bus0.stall = vecs[i].stall;
      #1;
      chk($sformatf("v%0d_req", i), 32'(bus0.imem_req), 32'(vecs[i].req));
      if (vecs[i].req) chk($sformatf("v%0d_addr", i), bus0.imem_addr, vecs[i].addr);
      step();
      chk($sformatf("v%0d_valid", i), 32'(bus0.valid_out), 32'(vecs[i].valid));
      if (vecs[i].valid) begin
        chk($sformatf("v%0d_pc", i), bus0.pc_out, vecs[i].pc);
        chk($sformatf("v%0d_instr", i), bus0.instruction_out, vecs[i].instr);
      end
    end

    // asynchronous reset clears live outputs without a clock edge
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus0.valid_out), 32'd0);
    chk("arst_pc", bus0.pc_out, 32'h0);
    chk("arst_instr", bus0.instruction_out, 32'h0);
    chk("arst_req", 32'(bus0.imem_req), 32'd0);

    // redirect while waiting, response two cycles later is dropped
    reset_all();
    step();
    step();
    step();
    step();
    chk("r33_pc4", bus0.pc_out, 32'h4);
    rv_delay = 3;
    step();
    bus0.redirect    = 1'b1;
    bus0.redirect_pc = 32'h100;
    step();
    bus0.redirect    = 1'b0;
    #1;
    chk("r33_drop_req", 32'(bus0.imem_req), 32'd0);
    chk("r33_drop_valid", 32'(bus0.valid_out), 32'd0);
    step();
    chk("r33_drop2_req", 32'(bus0.imem_req), 32'd0);
    chk("r33_drop2_valid", 32'(bus0.valid_out), 32'd0);
    rv_delay = 1;
    step();
    chk("r33_late_valid", 32'(bus0.valid_out), 32'd0);
    chk("r33_req", 32'(bus0.imem_req), 32'd1);
    chk("r33_addr", bus0.imem_addr, 32'h100);
    step();
    chk("r33_wait_valid", 32'(bus0.valid_out), 32'd0);
    step();
    chk("r33_valid", 32'(bus0.valid_out), 32'd1);
    chk("r33_pc", bus0.pc_out, 32'h100);
    chk("r33_instr", bus0.instruction_out, 32'hA5A5_A4A5);

    // unaligned redirect coinciding with a response
    reset_all();
    step();
    bus0.redirect    = 1'b1;
    bus0.redirect_pc = 32'h203;
    step();
    bus0.redirect    = 1'b0;
    #1;
    chk("r34_valid", 32'(bus0.valid_out), 32'd0);
    chk("r34_req", 32'(bus0.imem_req), 32'd1);
    chk("r34_addr", bus0.imem_addr, 32'h200);
    step();
    chk("r34_wait_valid", 32'(bus0.valid_out), 32'd0);
    step();
    chk("r34_pc", bus0.pc_out, 32'h200);
    chk("r34_instr", bus0.instruction_out, 32'hA5A5_A7A5);

    // a second redirect while draining replaces the target
    reset_all();
    rv_delay = 3;
    step();
    bus0.redirect    = 1'b1;
    bus0.redirect_pc = 32'h40;
    step();
    bus0.redirect_pc = 32'h80;
    step();
    bus0.redirect    = 1'b0;
    #1;
    chk("r26_drop_req", 32'(bus0.imem_req), 32'd0);
    rv_delay = 1;
    step();
    chk("r26_req", 32'(bus0.imem_req), 32'd1);
    chk("r26_addr", bus0.imem_addr, 32'h80);
    step();
    step();
    chk("r26_valid", 32'(bus0.valid_out), 32'd1);
    chk("r26_pc", bus0.pc_out, 32'h80);

    // reset during WAIT, stale response arrives one cycle after release
    reset_all();
    rv_delay = 3;
    step();
    rst = 1'b1;
    #1;
    chk("r36_rst_req", 32'(bus0.imem_req), 32'd0);
    step();
    step();
    rst           = 1'b0;
    bus0.imem_gnt = 1'b0;
    step();
    chk("r36_stale_valid", 32'(bus0.valid_out), 32'd0);
    bus0.imem_gnt = 1'b1;
    rv_delay      = 1;
    #1;
    chk("r36_req", 32'(bus0.imem_req), 32'd1);
    chk("r36_addr", bus0.imem_addr, 32'h0);
    step();
    chk("r36_wait_valid", 32'(bus0.valid_out), 32'd0);
    step();
    chk("r36_valid", 32'(bus0.valid_out), 32'd1);
    chk("r36_pc", bus0.pc_out, 32'h0);
    chk("r36_instr", bus0.instruction_out, 32'hA5A5_A5A5);

    // PC wrap from the top of the address space
    rst1 = 1'b0;
    #1;
    chk("r35_addr0", bus1.imem_addr, 32'hFFFF_FFFC);
    step();
    step();
    chk("r35_valid0", 32'(bus1.valid_out), 32'd1);
    chk("r35_pc0", bus1.pc_out, 32'hFFFF_FFFC);
    chk("r35_instr0", bus1.instruction_out, 32'h5A5A_5A59);
    chk("r35_addr1", bus1.imem_addr, 32'h0);
    step();
    step();
    chk("r35_valid1", 32'(bus1.valid_out), 32'd1);
    chk("r35_pc1", bus1.pc_out, 32'h0);
    chk("r35_instr1", bus1.instruction_out, 32'hA5A5_A5A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
